imm_gen_pipe: RTL
=================

IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 SHALL provide parameter XLEN, default 64, output immediate width; legal values 32 and 64.
REQ-002 SHALL provide parameter CNT_W, default 8, width of the illegal-request counter.
REQ-003 SHALL have port clk, input, 1, single clock; all state rises on its posedge.
REQ-004 SHALL have port rst_n, input, 1, reset, asynchronous assert, active-low.
REQ-005 SHALL have port in_valid, input, 1, request present.
REQ-006 SHALL have port in_ready, output, 1, request accepted when in_valid && in_ready.
REQ-007 SHALL have port in_inst, input, 32, instruction word.
REQ-008 SHALL have port in_mode, input, 3, immediate format select.
REQ-009 SHALL have port out_valid, output, 1, result present.
REQ-010 SHALL have port out_ready, input, 1, consumer accepts when out_valid && out_ready.
REQ-011 SHALL have port out_imm, output, XLEN, extended immediate.
REQ-012 SHALL have port out_err, output, 1, result belongs to an illegal request.
REQ-013 SHALL have port err_cnt, output, CNT_W, saturating count of illegal requests accepted.

Function
REQ-014 SHALL decode in_mode as follows:
- 000: zero-extend inst[21:10].
- 001: sign-extend inst[20:12].
- 010: sign-extend {inst[25:0],2'b00}.
- 011: sign-extend {inst[23:5],2'b00}.
- 100: zero-extend inst[20:5] shifted left by 16*inst[22:21].
- 101: zero-extend inst[21:10], shifted left by 12 when inst[22]=1.
REQ-015 SHALL treat modes 110 and 111 as illegal: out_imm=0, out_err=1.
REQ-016 SHALL treat mode 100 with XLEN=32 and inst[22:21]>=2 as illegal: out_imm=0, out_err=1.
REQ-017 SHALL perform all extension at full XLEN width, then truncate to XLEN bits; no other wrap.
REQ-018 SHALL compute each result from in_inst/in_mode at acceptance and register it; latency is 1 cycle from the accepting edge to out_valid=1.
REQ-019 SHALL hold out_imm, out_err and out_valid stable while out_valid=1 and out_ready=0.
REQ-020 SHALL sustain one transfer per cycle when out_ready=1 continuously.
REQ-021 SHALL, when in_valid=0 and the output is consumed, deassert out_valid on the next edge.
REQ-022 SHALL increment err_cnt by 1 per accepted illegal request, saturating at all-ones.
REQ-023 SHALL keep in_ready independent of in_valid; there is no combinational in_valid->in_ready path.

Reset
REQ-024 SHALL, while rst_n=0, force the following: out_valid=0, out_imm=0, out_err=0, err_cnt=0, all internal buffers empty.
REQ-025 SHALL drive in_ready to 1 in the first cycle after rst_n deasserts.
REQ-026 SHALL discard any in-flight or buffered result when reset asserts mid-operation; nothing is replayed.

Configuration
REQ-027 SHALL support macro IMM_GEN_SKID_EN.
- Defined: a 2-entry skid buffer is added, and in_ready is a registered signal = !skid_full.
- Not defined: single-stage operation with in_ready = !out_valid || out_ready.
REQ-028 SHALL produce identical data ordering and values with or without IMM_GEN_SKID_EN; only backpressure timing differs.

Structure
REQ-029 SHALL place the following in a shared package imm_gen_pkg: the mode encodings (IMM_ALU, IMM_DT, IMM_BR, IMM_CB, IMM_IW, IMM_ALU_SH) and a result typedef {imm, err}.
REQ-030 SHALL isolate the combinational format decode in sub-module imm_decode, parametrised by XLEN; the top holds only pipeline, skid and counter state.

Verification
REQ-031 SHALL cover the following directed scenarios (XLEN=64 unless stated):
- mode 010, inst=0x03FFFFFF, out_ready=1 -> next cycle out_imm=0xFFFFFFFFFFFFFFFC, out_err=0.
- mode 000, inst=0x003FFC00 -> out_imm=0x0000000000000FFF.
- mode 100, inst=0x0077DDE0 -> out_imm=0xBEEF000000000000. With XLEN=32 the same request -> out_imm=0, out_err=1, err_cnt=1.
- Backpressure with macro defined: out_ready=0, three back-to-back requests -> first two accepted, in_ready=0 on the third. Release out_ready -> results emerge in order, one per cycle, with no loss or duplication.
- Error counter with CNT_W=2: five requests with mode 111 -> err_cnt sequence 1,2,3,3,3.
- Mid-transfer reset: rst_n pulled low while out_valid=1 and out_ready=0 -> out_valid=0 immediately (asynchronous). After release, in_ready=1 and no stale result appears.

Source files
------------

// File: rtl/imm_gen_pkg.sv
// imm_gen_pkg: shared immediate-format encodings and the registered result type
package imm_gen_pkg;
  localparam logic [2:0] IMM_ALU    = 3'd0;
  localparam logic [2:0] IMM_DT     = 3'd1;
  localparam logic [2:0] IMM_BR     = 3'd2;
  localparam logic [2:0] IMM_CB     = 3'd3;
  localparam logic [2:0] IMM_IW     = 3'd4;
  localparam logic [2:0] IMM_ALU_SH = 3'd5;
  localparam int MAX_XLEN = 64;
  typedef struct packed {
    logic [MAX_XLEN-1:0] imm;
    logic                err;
  } imm_res_t;
endpackage

// File: rtl/imm_gen_pipe_if.sv
// imm_gen_pipe_if: request/result handshake bundle (master = producer/consumer side, slave = imm_gen_pipe)
interface imm_gen_pipe_if #(parameter int XLEN = 64);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_inst;
  logic [2:0]      in_mode;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_imm;
  logic            out_err;
  modport master(output in_valid, in_inst, in_mode, out_ready, input in_ready, out_valid, out_imm, out_err);
  modport slave(input in_valid, in_inst, in_mode, out_ready, output in_ready, out_valid, out_imm, out_err);
endinterface

// File: rtl/imm_decode.sv
// imm_decode: combinational immediate extraction; inst/mode in, {imm, err} out, imm truncated to XLEN
module imm_decode import imm_gen_pkg::*; #(
  parameter int XLEN = 64
) (
  input  logic [31:0] inst,
  input  logic [2:0]  mode,
  output imm_res_t    res
);
  logic [XLEN-1:0] alu, dt, br, cb, iw, sh, imm;
  logic bad;
  logic unused_hi;
  assign unused_hi = ^inst[31:26];
  always_comb begin
    alu = XLEN'(inst[21:10]);
    dt  = {{(XLEN-9){inst[20]}}, inst[20:12]};
    br  = {{(XLEN-28){inst[25]}}, inst[25:0], 2'b00};
    cb  = {{(XLEN-21){inst[23]}}, inst[23:5], 2'b00};
    iw  = XLEN'(inst[20:5]) << {inst[22:21], 4'b0000};
    sh  = inst[22] ? alu << 12 : alu;
    // a 32-bit result cannot hold halfword positions 2 and 3
    bad = (mode[2] & mode[1]) | (mode == IMM_IW && XLEN == 32 && inst[22]);
    imm = bad                ? '0  :
          mode == IMM_ALU    ? alu :
          mode == IMM_DT     ? dt  :
          mode == IMM_BR     ? br  :
          mode == IMM_CB     ? cb  :
          mode == IMM_IW     ? iw  : sh;
    res = '{imm: MAX_XLEN'(imm), err: bad};
  end
endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered immediate generator with handshake, optional skid buffer (IMM_GEN_SKID_EN) and saturating illegal-request counter; ports clk, rst_n, bus (imm_gen_pipe_if.slave), err_cnt
module imm_gen_pipe import imm_gen_pkg::*; #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  imm_gen_pipe_if.slave    bus,
  output logic [CNT_W-1:0] err_cnt
);
  imm_res_t res, head;
  logic acc;
  imm_decode #(.XLEN(XLEN)) u_dec (.inst(bus.in_inst), .mode(bus.in_mode), .res(res));
  assign acc = bus.in_valid && bus.in_ready;
  assign bus.out_imm = head.imm[XLEN-1:0];
  assign bus.out_err = head.err;
`ifdef IMM_GEN_SKID_EN
  imm_res_t mem [2];
  logic rd, wr, rdy, pop;
  logic [1:0] cnt, cnt_nx;
  assign pop = bus.out_valid && bus.out_ready;
  assign cnt_nx = cnt + 2'(acc) - 2'(pop);
  assign head = mem[rd];
  assign bus.out_valid = cnt != 2'd0;
  assign bus.in_ready = rdy;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd     <= 1'b0;
      wr     <= 1'b0;
      cnt    <= 2'd0;
      rdy    <= 1'b1;
    end else begin
      if (acc) begin
        mem[wr] <= res;
        wr      <= !wr;
      end
      if (pop) rd <= !rd;
      cnt <= cnt_nx;
      rdy <= cnt_nx != 2'd2;
    end
`else
  logic vld;
  assign bus.out_valid = vld;
  assign bus.in_ready = !vld || bus.out_ready;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      vld  <= 1'b0;
      head <= '0;
    end else if (acc) begin
      vld  <= 1'b1;
      head <= res;
    end else if (bus.out_ready) vld <= 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) err_cnt <= '0;
    else if (acc && res.err && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
endmodule
